// File: rtl/uart_clk_gen.sv
// uart_clk_gen: baud-rate enable generator for the UART TX/RX engines.
// Produces a one-clock tx_clk_en strobe per bit period and a one-clock
// rx_clk_en strobe OVERSAMPLE times per bit period, from a baud table
// selected by baud_rate. Divisors are rounded to nearest and clamped to 2.
module uart_clk_gen #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int OVERSAMPLE      = 16,
    parameter int BAUD_RATES [16] = '{300, 600, 1200, 2400, 4800, 9600, 14400, 19200,
                                      28800, 38400, 57600, 76800, 115200, 230400,
                                      460800, 921600}
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       active,
    input  logic [3:0] baud_rate,
    output logic       tx_clk_en,
    output logic       rx_clk_en
);

    // Rounded divisor for table entry idx at os strobes per bit, never below 2.
    function automatic int calc_div(input int idx, input int os);
        longint b;
        longint d;
        b = longint'(BAUD_RATES[idx]) * longint'(os);
        d = (longint'(CLK_FREQ) + b / 2) / b;
        if (d < 2) d = 2;
        return int'(d);
    endfunction

    // Largest divisor in the table, used to size the counters.
    function automatic int max_div(input int os);
        int m;
        m = 2;
        for (int i = 0; i < 16; i++) begin
            if (calc_div(i, os) > m) m = calc_div(i, os);
        end
        return m;
    endfunction

    localparam int TX_W = $clog2(max_div(1));
    localparam int RX_W = $clog2(max_div(OVERSAMPLE));

    // Terminal counts (DIV-1) so the counter width only has to hold 0..DIV-1.
    logic [TX_W-1:0] tx_term [16];
    logic [RX_W-1:0] rx_term [16];

    for (genvar g = 0; g < 16; g++) begin : g_div
        assign tx_term[g] = TX_W'(calc_div(g, 1) - 1);
        assign rx_term[g] = RX_W'(calc_div(g, OVERSAMPLE) - 1);
    end

    logic [3:0]      baud_q;
    logic [TX_W-1:0] tx_cnt;
    logic [RX_W-1:0] rx_cnt;
    logic            baud_chg;
    logic            hold;

    // A baud change restarts both periods; inactive holds everything at 0.
    // Deasserting active and a baud change both win over a terminal count.
    assign baud_chg = (baud_rate != baud_q);
    assign hold     = !active || baud_chg;

    // Track the selected baud index one cycle behind to detect changes.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            baud_q <= 4'd0;
        end else begin
            baud_q <= baud_rate;
        end
    end

    // TX divider: count 0..DIV-1, strobe registered in the cycle after DIV-1.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            tx_cnt    <= '0;
            tx_clk_en <= 1'b0;
        end else if (hold) begin
            tx_cnt    <= '0;
            tx_clk_en <= 1'b0;
        end else if (tx_cnt == tx_term[baud_q]) begin
            tx_cnt    <= '0;
            tx_clk_en <= 1'b1;
        end else begin
            tx_cnt    <= tx_cnt + TX_W'(1);
            tx_clk_en <= 1'b0;
        end
    end

    // RX divider: same scheme at the oversampled rate, independent phase.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_cnt    <= '0;
            rx_clk_en <= 1'b0;
        end else if (hold) begin
            rx_cnt    <= '0;
            rx_clk_en <= 1'b0;
        end else if (rx_cnt == rx_term[baud_q]) begin
            rx_cnt    <= '0;
            rx_clk_en <= 1'b1;
        end else begin
            rx_cnt    <= rx_cnt + RX_W'(1);
            rx_clk_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_clk_gen.sv
// tb_uart_clk_gen: bench for uart_clk_gen. Strobe timestamps (cycle numbers)
// are collected from the DUT and compared against a model that predicts each
// strobe as an arithmetic progression anchored at the last restart event.
module tb_uart_clk_gen;

    localparam int CLK_FREQ   = 50_000_000;
    localparam int OVERSAMPLE = 16;
    localparam int TB_BAUD [16] = '{300, 600, 1200, 2400, 4800, 9600, 14400, 19200,
                                    28800, 38400, 57600, 76800, 115200, 230400,
                                    460800, 921600};

    logic       clk = 1'b0;
    logic       arst;
    logic       active;
    logic [3:0] baud_rate;
    logic       tx_clk_en;
    logic       rx_clk_en;

    uart_clk_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .active    (active),
        .baud_rate (baud_rate),
        .tx_clk_en (tx_clk_en),
        .rx_clk_en (rx_clk_en)
    );

    // Clock and cycle counter: cyc is the number of the most recent rising edge.
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes, encoded as cycle*2 + (0 = tx, 1 = rx).
    logic [31:0] act_q[$];
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (tx_clk_en === 1'b1) act_q.push_back(32'(cyc * 2));
        if (rx_clk_en === 1'b1) act_q.push_back(32'(cyc * 2 + 1));
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: applied inputs and next predicted strobe cycles.
    bit         m_rst;
    bit         m_act;
    bit         m_run;
    logic [3:0] m_baud;
    int         m_tx_div;
    int         m_rx_div;
    int         m_tx_next;
    int         m_rx_next;

    function automatic int ref_tx_div(input int idx);
        int b;
        int d;
        b = TB_BAUD[idx];
        d = (CLK_FREQ + b / 2) / b;
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int ref_rx_div(input int idx);
        int b;
        int d;
        b = TB_BAUD[idx];
        d = (CLK_FREQ + (OVERSAMPLE / 2) * b) / (OVERSAMPLE * b);
        return (d < 2) ? 2 : d;
    endfunction

    // Emit every predicted strobe up to and including cycle upto.
    task automatic model_advance(input int upto);
        if (m_run) begin
            while (m_tx_next <= upto) begin
                exp_q.push_back(32'(m_tx_next * 2));
                m_tx_next += m_tx_div;
            end
            while (m_rx_next <= upto) begin
                exp_q.push_back(32'(m_rx_next * 2 + 1));
                m_rx_next += m_rx_div;
            end
        end
    endtask

    // Periods restart at cycle r: strobes then fall at r+DIV, r+2*DIV, ...
    task automatic model_anchor(input int r);
        m_tx_div  = ref_tx_div(int'(m_baud));
        m_rx_div  = ref_rx_div(int'(m_baud));
        m_tx_next = r + m_tx_div;
        m_rx_next = r + m_rx_div;
        m_run     = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step(1);
    endtask

    // Drive new inputs just after rising edge cyc and update the model.
    task automatic apply(input bit rst, input bit act, input logic [3:0] baud);
        int n0;
        int r;
        n0 = cyc;
        if (rst) begin
            // Asynchronous: the strobe launched at edge n0 is wiped before sampling.
            if (!m_rst) model_advance(n0 - 1);
            m_run  = 1'b0;
            m_baud = 4'd0;
        end else if (m_rst) begin
            if (act) begin
                r = (baud != 4'd0) ? n0 + 1 : n0;
                m_baud = baud;
                model_anchor(r);
            end else begin
                m_baud = baud;
                m_run  = 1'b0;
            end
        end else begin
            model_advance(n0);
            if (!act) begin
                m_run  = 1'b0;
                m_baud = baud;
            end else if (!m_act || baud != m_baud) begin
                r = (baud != m_baud) ? n0 + 1 : n0;
                m_baud = baud;
                model_anchor(r);
            end
        end
        m_rst     = rst;
        m_act     = act;
        arst      = rst;
        active    = act;
        baud_rate = baud;
    endtask

    task automatic test_reset;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (tx_clk_en !== 1'b0) begin
                n_err++;
                $display("FAIL reset tx_clk_en actual=%b expected=0", tx_clk_en);
            end
            n_cmp++;
            if (rx_clk_en !== 1'b0) begin
                n_err++;
                $display("FAIL reset rx_clk_en actual=%b expected=0", rx_clk_en);
            end
        end
        model_advance(cyc);
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL reset strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_baud_9600;
        step(1);
        apply(1'b0, 1'b1, 4'd5);
        run_to(cyc + 2 * ref_tx_div(5) + 3);
        @(negedge clk);
        #1;
        model_advance(cyc);
        exp_q.sort();
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL baud_9600 strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL baud_9600 strobe[%0d] actual=%s@%0d expected=%s@%0d", i,
                         act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                         exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_fast_rates;
        step($urandom_range(10, 200));
        apply(1'b0, 1'b1, 4'd15);
        run_to(cyc + 3 * ref_tx_div(15) + 3);
        step($urandom_range(1, 60));
        apply(1'b0, 1'b1, 4'd12);
        run_to(cyc + 2 * ref_tx_div(12) + 3);
        @(negedge clk);
        #1;
        model_advance(cyc);
        exp_q.sort();
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL fast_rates strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL fast_rates strobe[%0d] actual=%s@%0d expected=%s@%0d", i,
                         act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                         exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_baud_sweep;
        int t;
        // Mid-period change 5 -> 6, then every index after a reset pulse.
        step(1);
        apply(1'b0, 1'b1, 4'd5);
        step($urandom_range(100, 3000));
        apply(1'b0, 1'b1, 4'd6);
        run_to(cyc + ref_tx_div(6) + 3);
        for (int idx = 0; idx < 16; idx++) begin
            step(1);
            apply(1'b1, 1'b1, 4'(idx));
            step(1);
            apply(1'b0, 1'b1, 4'(idx));
            t = (idx < 7) ? cyc + ref_rx_div(idx) + 3 : cyc + 2 * ref_tx_div(idx) + 3;
            run_to(t);
            @(negedge clk);
            #1;
            model_advance(cyc);
            exp_q.sort();
            n_cmp++;
            if (act_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL sweep_%0d strobe_count actual=%0d expected=%0d", idx, act_q.size(), exp_q.size());
            end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (act_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL sweep_%0d strobe[%0d] actual=%s@%0d expected=%s@%0d", idx, i,
                             act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                             exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                    break;
                end
            end
            act_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_active;
        step(1);
        apply(1'b0, 1'b1, 4'd9);
        step($urandom_range(500, 1500));
        apply(1'b0, 1'b0, 4'd9);
        run_to(cyc + 100);
        step(1);
        apply(1'b0, 1'b1, 4'd9);
        run_to(cyc + 2 * ref_tx_div(9) + 3);
        @(negedge clk);
        #1;
        model_advance(cyc);
        exp_q.sort();
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL active strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL active strobe[%0d] actual=%s@%0d expected=%s@%0d", i,
                         act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                         exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        bit found;
        step(1);
        apply(1'b0, 1'b1, 4'd10);
        step($urandom_range(100, 800));
        // Land the reset while an rx strobe is high to show it clears at once.
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step(1);
            if (rx_clk_en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_mid rx_wait actual=timeout expected=strobe");
        end
        apply(1'b1, 1'b1, 4'd10);
        #1;
        n_cmp++;
        if (tx_clk_en !== 1'b0 || rx_clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid async_clear actual=%b%b expected=00", tx_clk_en, rx_clk_en);
        end
        step(ref_tx_div(10));
        apply(1'b0, 1'b1, 4'd10);
        run_to(cyc + 2 * ref_tx_div(10) + 3);
        @(negedge clk);
        #1;
        model_advance(cyc);
        exp_q.sort();
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL reset_mid strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL reset_mid strobe[%0d] actual=%s@%0d expected=%s@%0d", i,
                         act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                         exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        bit         act;
        logic [3:0] baud;
        act  = 1'b1;
        baud = 4'd10;
        for (int it = 0; it < 12; it++) begin
            step($urandom_range(20, 400));
            if ($urandom_range(0, 3) == 0) begin
                act = !act;
            end else begin
                baud = 4'($urandom_range(8, 15));
            end
            apply(1'b0, act, baud);
        end
        step(1);
        apply(1'b0, 1'b1, baud);
        run_to(cyc + 300);
        @(negedge clk);
        #1;
        model_advance(cyc);
        exp_q.sort();
        n_cmp++;
        if (act_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random strobe_count actual=%0d expected=%0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (act_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL random strobe[%0d] actual=%s@%0d expected=%s@%0d", i,
                         act_q[i][0] ? "rx" : "tx", act_q[i] >> 1,
                         exp_q[i][0] ? "rx" : "tx", exp_q[i] >> 1);
                break;
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        arst      = 1'b1;
        active    = 1'b1;
        baud_rate = 4'd5;
        m_rst     = 1'b1;
        m_act     = 1'b1;
        m_run     = 1'b0;
        m_baud    = 4'd0;
        m_tx_div  = 2;
        m_rx_div  = 2;
        m_tx_next = 0;
        m_rx_next = 0;
        test_reset();
        test_baud_9600();
        test_fast_rates();
        test_baud_sweep();
        test_active();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard time limit in case a wait never completes.
    initial begin
        #4_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "time limit reached");
    end

endmodule
